// File: rtl/prox_guard.sv
// -----------------------------------------------------------------------------
// prox_guard
//
// Proximity guard between the steering decoder and the servo PWM generator.
// Front and rear proximity sensors are synchronised and debounced. Each side
// keeps its clamp for a hold time after its flag clears. A lock FSM then
// clamps the servo pulse-width command so the platform cannot drive toward
// a detected obstacle.
//
// Configuration macro:
//   PROX_GUARD_RAMP_EN - when defined, the output slews toward the clamp
//                        target by at most STEP per cycle in every non-CLEAR
//                        state. When undefined, the output jumps to the
//                        target in a single cycle.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   prox_front    in   [N_FRONT] raw front sensors, 1 = obstacle (async)
//   prox_rear     in   [N_REAR]  raw rear sensors,  1 = obstacle (async)
//   x_val         in   [W] requested pulse width (us, NEUTRAL = stop)
//   x_val_checked out  [W] guarded pulse width, registered
//   front_lock    out  front clamp active (registered)
//   rear_lock     out  rear clamp active (registered)
//   stop          out  both clamps active (registered)
// -----------------------------------------------------------------------------
module prox_guard #(
  parameter int W           = 11,
  parameter int NEUTRAL     = 1500,
  parameter int N_FRONT     = 2,
  parameter int N_REAR      = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int STEP        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FRONT-1:0] prox_front,
  input  logic [N_REAR-1:0]  prox_rear,
  input  logic [W-1:0]       x_val,
  output logic [W-1:0]       x_val_checked,
  output logic               front_lock,
  output logic               rear_lock,
  output logic               stop
);

  // Counter widths. The hold counter keeps at least one bit so that
  // HOLD_CYCLES = 0 still builds; it then never loads a non-zero value.
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [W-1:0]  NEUTRAL_W = W'(NEUTRAL);
  localparam logic [DW-1:0] DEB_ZERO  = DW'(0);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    CLEAR    = 2'b00,
    FWD_LOCK = 2'b01,
    REV_LOCK = 2'b10,
    STOP     = 2'b11
  } state_t;

  // Saturating decrement for the hold counter.
  function automatic logic [HW-1:0] hold_dec(input logic [HW-1:0] h);
    logic [HW-1:0] r;
    if (h == HOLD_ZERO) begin
      r = HOLD_ZERO;
    end else begin
      r = h - HOLD_ONE;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (a < b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] max_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

`ifdef PROX_GUARD_RAMP_EN
  localparam logic [W:0] STEP_W = (W+1)'(STEP);

  // One slew step from cur toward tgt, done in W+1 bits so neither the
  // difference nor cur +/- STEP can wrap.
  function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0]   c;
    logic [W:0]   t;
    logic [W:0]   m;
    logic [W-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) begin
      if ((t - c) <= STEP_W) begin
        m = t;
      end else begin
        m = c + STEP_W;
      end
    end else begin
      if ((c - t) <= STEP_W) begin
        m = t;
      end else begin
        m = c - STEP_W;
      end
    end
    r = m[W-1:0];
    return r;
  endfunction
`endif

  logic [N_FRONT-1:0] front_s1_r;
  logic [N_FRONT-1:0] front_s2_r;
  logic [N_REAR-1:0]  rear_s1_r;
  logic [N_REAR-1:0]  rear_s2_r;
  logic [1:0]         cond_s;       // [0] = front, [1] = rear
  logic [1:0]         flag_r;
  logic [DW-1:0]      deb_cnt_r [2];
  logic [HW-1:0]      hold_r    [2];
  logic [1:0]         clamp_s;
  state_t             state_r;
  logic [W-1:0]       target_s;
  logic [W-1:0]       next_out_s;

  // Two-stage synchronisers for every raw sensor bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_s1_r <= {N_FRONT{1'b0}};
      front_s2_r <= {N_FRONT{1'b0}};
      rear_s1_r  <= {N_REAR{1'b0}};
      rear_s2_r  <= {N_REAR{1'b0}};
    end else begin
      front_s1_r <= prox_front;
      front_s2_r <= front_s1_r;
      rear_s1_r  <= prox_rear;
      rear_s2_r  <= rear_s1_r;
    end
  end

  // A side sees an obstacle only when all of its sensors agree.
  assign cond_s[0] = &front_s2_r;
  assign cond_s[1] = &rear_s2_r;

  // Per-side debounce and post-release hold. The debounce counter runs only
  // while the condition disagrees with the flag; the hold counter is loaded
  // when the flag falls and cleared when the flag rises again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
        hold_r[i]    <= HOLD_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cond_s[i] != flag_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_cnt_r[i] <= DEB_ZERO;
            flag_r[i]    <= cond_s[i];
            if (cond_s[i]) begin
              hold_r[i] <= HOLD_ZERO;
            end else begin
              hold_r[i] <= HOLD_LD;
            end
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
            hold_r[i]    <= hold_dec(hold_r[i]);
          end
        end else begin
          deb_cnt_r[i] <= DEB_ZERO;
          hold_r[i]    <= hold_dec(hold_r[i]);
        end
      end
    end
  end

  assign clamp_s[0] = flag_r[0] | (hold_r[0] != HOLD_ZERO);
  assign clamp_s[1] = flag_r[1] | (hold_r[1] != HOLD_ZERO);

  // Lock FSM: next state follows the clamp pair directly; the lock outputs
  // are registered together with the state so they match it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= CLEAR;
      front_lock <= 1'b0;
      rear_lock  <= 1'b0;
      stop       <= 1'b0;
    end else begin
      case (clamp_s)
        2'b01: begin
          state_r    <= FWD_LOCK;
          front_lock <= 1'b1;
          rear_lock  <= 1'b0;
          stop       <= 1'b0;
        end
        2'b10: begin
          state_r    <= REV_LOCK;
          front_lock <= 1'b0;
          rear_lock  <= 1'b1;
          stop       <= 1'b0;
        end
        2'b11: begin
          state_r    <= STOP;
          front_lock <= 1'b1;
          rear_lock  <= 1'b1;
          stop       <= 1'b1;
        end
        default: begin
          state_r    <= CLEAR;
          front_lock <= 1'b0;
          rear_lock  <= 1'b0;
          stop       <= 1'b0;
        end
      endcase
    end
  end

  // Clamp target from the registered state: a front lock forbids forward
  // motion (values above NEUTRAL), a rear lock forbids reverse.
  always_comb begin
    target_s = x_val;
    case (state_r)
      FWD_LOCK: target_s = min_w(x_val, NEUTRAL_W);
      REV_LOCK: target_s = max_w(x_val, NEUTRAL_W);
      STOP:     target_s = NEUTRAL_W;
      default:  target_s = x_val;
    endcase
  end

  // Next output value: CLEAR always passes straight through.
  always_comb begin
    next_out_s = target_s;
`ifdef PROX_GUARD_RAMP_EN
    if (state_r == CLEAR) begin
      next_out_s = target_s;
    end else begin
      next_out_s = ramp_step(x_val_checked, target_s);
    end
`else
    next_out_s = target_s;
`endif
  end

  // Guarded output register; reset forces NEUTRAL asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_val_checked <= NEUTRAL_W;
    end else begin
      x_val_checked <= next_out_s;
    end
  end

endmodule

// File: tb/tb_prox_guard.sv
// -----------------------------------------------------------------------------
// tb_prox_guard
//
// Table-driven bench for prox_guard with DEB_CYCLES=4, HOLD_CYCLES=8,
// STEP=100, NEUTRAL=1500. Each vector drives inputs on a falling edge, waits
// a given number of rising edges, and checks all outputs on the next falling
// edge. Reset behaviour is covered by short hand-written sequences. Expected
// outputs that depend on PROX_GUARD_RAMP_EN are selected at compile time.
// -----------------------------------------------------------------------------
module tb_prox_guard;

  localparam int W = 11;

`ifdef PROX_GUARD_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [1:0]   prox_front;
  logic [1:0]   prox_rear;
  logic [W-1:0] x_val;
  logic [W-1:0] x_val_checked;
  logic         front_lock;
  logic         rear_lock;
  logic         stop;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]   pf;
    logic [1:0]   pr;
    logic [W-1:0] x;
    int           n;
    logic [W-1:0] eo;
    logic         fl;
    logic         rl;
    logic         st;
  } vec_t;

  vec_t vecs[$];

  prox_guard #(
    .W(11), .NEUTRAL(1500), .N_FRONT(2), .N_REAR(2),
    .DEB_CYCLES(4), .HOLD_CYCLES(8), .STEP(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prox_front(prox_front),
    .prox_rear(prox_rear),
    .x_val(x_val),
    .x_val_checked(x_val_checked),
    .front_lock(front_lock),
    .rear_lock(rear_lock),
    .stop(stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [W-1:0] eo, input logic fl, input logic rl, input logic st);
    chk("out", idx, 32'(x_val_checked), 32'(eo));
    chk("front_lock", idx, 32'(front_lock), 32'(fl));
    chk("rear_lock", idx, 32'(rear_lock), 32'(rl));
    chk("stop", idx, 32'(stop), 32'(st));
  endtask

  function automatic void add(input logic [1:0] pf, input logic [1:0] pr, input int x, input int n,
                              input int eo, input logic fl, input logic rl, input logic st);
    vec_t v;
    v.pf = pf; v.pr = pr; v.x = W'(x); v.n = n;
    v.eo = W'(eo); v.fl = fl; v.rl = rl; v.st = st;
    vecs.push_back(v);
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // pass-through, including width extremes
    add(2'b00, 2'b00, 1000, 1, 1000, 1'b0, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2047, 1, 2047, 1'b0, 1'b0, 1'b0);
    add(2'b00, 2'b00,    0, 1,    0, 1'b0, 1'b0, 1'b0);
    // glitch: 3-cycle pulse, then single-bit sensors held high
    add(2'b11, 2'b00, 1800,  3, 1800, 1'b0, 1'b0, 1'b0);
    add(2'b00, 2'b00, 1800, 10, 1800, 1'b0, 1'b0, 1'b0);
    add(2'b01, 2'b00, 1700, 20, 1700, 1'b0, 1'b0, 1'b0);
    add(2'b10, 2'b00, 1600, 20, 1600, 1'b0, 1'b0, 1'b0);
    // front block: lock exactly 7 cycles after the edge
    add(2'b11, 2'b00, 1800, 6, 1800, 1'b0, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1800, 1, 1800, 1'b1, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1800, 1, RAMP ? 1700 : 1500, 1'b1, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1800, 1, RAMP ? 1600 : 1500, 1'b1, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1800, 1, 1500, 1'b1, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1200, 3, 1200, 1'b1, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1900, 3, 1500, 1'b1, 1'b0, 1'b0);
    // front release: 2 sync + 4 debounce + 8 hold, then 1 state cycle
    add(2'b00, 2'b00, 1800, 14, 1500, 1'b1, 1'b0, 1'b0);
    add(2'b00, 2'b00, 1800,  1, 1500, 1'b0, 1'b0, 1'b0);
    add(2'b00, 2'b00, 1800,  1, 1800, 1'b0, 1'b0, 1'b0);
    // rear block
    add(2'b00, 2'b11, 1200, 7, 1200, 1'b0, 1'b1, 1'b0);
    add(2'b00, 2'b11, 1200, 3, 1500, 1'b0, 1'b1, 1'b0);
    add(2'b00, 2'b11, 1900, 4, 1900, 1'b0, 1'b1, 1'b0);
    // both sides
    add(2'b11, 2'b11, 1000, 7, 1500, 1'b1, 1'b1, 1'b1);
    add(2'b11, 2'b11, 2000, 2, 1500, 1'b1, 1'b1, 1'b1);
    // drop rear: FWD_LOCK after debounce plus hold
    add(2'b11, 2'b00, 2000, 14, 1500, 1'b1, 1'b1, 1'b1);
    add(2'b11, 2'b00, 2000,  1, 1500, 1'b1, 1'b0, 1'b0);
    // back to CLEAR, then both sides assert in the same cycle
    add(2'b00, 2'b00, 2000, 40, 2000, 1'b0, 1'b0, 1'b0);
    add(2'b11, 2'b11, 2000,  6, 2000, 1'b0, 1'b0, 1'b0);
    add(2'b11, 2'b11, 2000,  1, 2000, 1'b1, 1'b1, 1'b1);
    add(2'b11, 2'b11, 2000,  1, RAMP ? 1900 : 1500, 1'b1, 1'b1, 1'b1);
    add(2'b11, 2'b11, 2000,  2, RAMP ? 1700 : 1500, 1'b1, 1'b1, 1'b1);

    // reset held: output NEUTRAL, locks clear
    rst = 1'b0;
    prox_front = 2'b00;
    prox_rear = 2'b00;
    x_val = W'(1800);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all(-1, W'(1500), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all(-2, W'(1800), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      prox_front = vecs[i].pf;
      prox_rear  = vecs[i].pr;
      x_val      = vecs[i].x;
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      chk_all(i, vecs[i].eo, vecs[i].fl, vecs[i].rl, vecs[i].st);
    end

    // reset mid-lock / mid-ramp takes effect without a clock edge
    #2;
    rst = 1'b0;
    #1;
    chk_all(-3, W'(1500), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // sensors still high, but the pipeline restarted in CLEAR
    chk_all(-4, W'(2000), 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
